cod_prio_drain: RTL and testbench
=================================

// Module: cod_prio_drain
// PURPOSE
// - Parametrised N-to-log2(N) encoder for request vectors with several bits set.
// - Captures one N-bit request vector, then emits the index of every set bit, one per
//   output handshake, in priority order. Bit i encodes to index i.
// - Feeds index-driven blocks (mux selects, IRQ vectors). Zero vectors are flagged, not encoded.
// PARAMETERS
// - N   8                    request vector width; N >= 2
// - W   $clog2(N) localparam index width (not overridable)
// PORTS
// - clk        in   1  clock, rising edge
// - rst_n      in   1  reset, asynchronous, active-low
// - req_in     in   N  request vector
// - req_valid  in   1  req_in is valid
// - req_ready  out  1  block can accept a vector
// - enc_out    out  W  index of the currently selected bit
// - enc_valid  out  1  enc_out is valid
// - enc_ready  in   1  downstream accepts enc_out
// - enc_last   out  1  enc_out is the last index of the captured vector
// - err_zero   out  1  one-cycle pulse: a zero vector was accepted
// - busy       out  1  vector being drained (state = EMIT)
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous): state=IDLE, pend=0, ptr=0, err_zero=0.
//   Resulting outputs: enc_valid=0, enc_out=0, enc_last=0, busy=0, req_ready=1.
// - Reset mid-drain discards the remaining pend bits. No further enc_valid is raised.
// - Internal registers: pend[N-1:0] (unserved bits), ptr[W-1:0] (priority start, RR only), state.
// - FSM IDLE: req_ready=1.
//   - Capture happens on req_valid && req_ready.
//   - Nonzero req_in: pend <= req_in and state -> EMIT.
//   - req_in==0: vector dropped, err_zero=1 for the next cycle only, stay in IDLE.
// - FSM EMIT: req_ready=0, busy=1, enc_valid=1.
//   - enc_out = selected bit of pend, computed from registers only.
//   - enc_last = 1 when popcount(pend)==1.
// - Latency: enc_valid rises in the cycle after capture.
// - Handshake (enc_valid && enc_ready): clear the selected bit in pend.
//   - If enc_last=1: state -> IDLE.
//   - Otherwise: stay in EMIT; the next index appears in the next cycle.
// - Sustained enc_ready=1 gives one index per cycle.
// - Back-pressure: while enc_valid && !enc_ready, enc_out and enc_last are held stable.
// - After the last handshake there is a mandatory 1-cycle bubble. req_ready rises in IDLE,
//   never in the same cycle as the last handshake.
// - req_in and req_valid are ignored in EMIT. No queueing.
// - Selection: lowest-index set bit of pend (bit 0 has highest priority). Ties impossible.
// - enc_out is never X. The old default-x behaviour is replaced by err_zero.
// - Index arithmetic is modulo N. For non-power-of-2 N, indices >= N never occur.
// CONFIGURATION
// - COD_RR_EN defined: round-robin priority.
//   - Selection is the first set bit of pend at or above ptr, wrapping from N-1 to 0.
//   - On each handshake: ptr <= (enc_out+1) mod N, so ptr wraps from N-1 to 0.
//   - ptr persists across vectors; only rst_n clears it.
// - COD_RR_EN undefined: fixed lowest-index priority. No ptr register.
// TESTING (N=8)
// - Reset: rst_n=0 -> enc_valid=0, enc_out=0, busy=0, req_ready=1, err_zero=0.
// - Single bit: req_in=8'h04 -> next cycle enc_out=2, enc_valid=1, enc_last=1;
//   enc_ready=1 -> IDLE, req_ready=1 one cycle later.
// - Multi-bit drain: req_in=8'h92, enc_ready=1 -> enc_out=1,4,7 on consecutive cycles;
//   enc_last=1 only with 7.
// - Back-pressure and zero vector:
//   - req_in=8'h92 with enc_ready=0 for 5 cycles -> enc_out=1 stable, enc_last=0.
//   - req_in=8'h00 -> err_zero pulses 1 cycle, enc_valid stays 0.
// - Reset mid-drain: req_in=8'hFF, rst_n=0 after 2 handshakes ->
//   enc_valid=0 immediately, pend=0; next vector 8'h01 emits 0.
// - Priority order: vector 8'h04 emits 2, then vector 8'h09.
//   - With COD_RR_EN the second vector emits 3,0.
//   - Without COD_RR_EN it emits 0,3.

Source files
------------

// File: rtl/cod_prio_drain_if.sv
// Request/encode handshake bundle for cod_prio_drain.
// slave = encoder side, master = requester/consumer side.
interface cod_prio_drain_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req_in;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] enc_out;
  logic         enc_valid;
  logic         enc_ready;
  logic         enc_last;

  modport slave (
    input  req_in, req_valid, enc_ready,
    output req_ready, enc_out, enc_valid, enc_last
  );

  modport master (
    output req_in, req_valid, enc_ready,
    input  req_ready, enc_out, enc_valid, enc_last
  );
endinterface

// File: rtl/cod_prio_drain.sv
// Captures an N-bit request vector and emits each set-bit index, one per handshake.
// Define COD_RR_EN for round-robin priority; default is fixed lowest-index-first.
module cod_prio_drain #(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cod_prio_drain_if.slave   bus,
  output logic              err_zero,
  output logic              busy
);
  localparam int W = $clog2(N);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       r_state;
  logic [N-1:0] r_pend;
  logic         r_err_zero;
`ifdef COD_RR_EN
  logic [W-1:0] r_ptr;
`endif

  logic [W-1:0] w_sel;
  logic         w_last;

  // Scan starts at the priority pointer (0 in fixed mode) and wraps at N.
  always_comb begin : select
    logic        found;
    logic [W-1:0] idx;
    int unsigned j;
    w_sel = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
`ifdef COD_RR_EN
      j = 32'(r_ptr) + i;
      if (j >= N) j = j - N;
`else
      j = i;
`endif
      idx = W'(j);
      if (!found && r_pend[idx]) begin
        w_sel = idx;
        found = 1'b1;
      end
    end
  end

  assign w_last = (r_pend != '0) && ((r_pend & (r_pend - N'(1))) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_err_zero <= 1'b0;
`ifdef COD_RR_EN
      r_ptr      <= '0;
`endif
    end else begin
      r_err_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_in != '0) begin
              r_pend  <= bus.req_in;
              r_state <= EMIT;
            end else begin
              r_err_zero <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.enc_ready) begin
            r_pend[w_sel] <= 1'b0;
`ifdef COD_RR_EN
            r_ptr <= (w_sel == W'(N - 1)) ? '0 : w_sel + 1'b1;
`endif
            if (w_last) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.enc_valid = (r_state == EMIT);
  assign bus.enc_out   = w_sel;
  assign bus.enc_last  = w_last;
  assign busy          = (r_state == EMIT);
  assign err_zero      = r_err_zero;
endmodule

// File: tb/tb_cod_prio_drain.sv
// Bench for cod_prio_drain: directed scenarios plus random traffic against a
// transaction-level model holding the pending indices as an ordered queue.
module tb_cod_prio_drain;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_zero;
  logic busy;

  cod_prio_drain_if #(.N(N)) bus();

  cod_prio_drain #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .err_zero (err_zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  int q[$];
  int m_ptr = 0;
  bit m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Emission order: set bits visited upward from the current priority start, wrapping.
  function automatic void load(input logic [N-1:0] v);
    int start;
`ifdef COD_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (v[idx]) q.push_back(idx);
    end
  endfunction

  task automatic check_outputs();
    if (q.size() > 0) begin
      chk("enc_valid", bus.enc_valid, 1);
      chk("enc_out",   bus.enc_out,   q[0]);
      chk("enc_last",  bus.enc_last,  (q.size() == 1) ? 1 : 0);
      chk("busy",      busy,          1);
      chk("req_ready", bus.req_ready, 0);
    end else begin
      chk("enc_valid", bus.enc_valid, 0);
      chk("enc_out",   bus.enc_out,   0);
      chk("enc_last",  bus.enc_last,  0);
      chk("busy",      busy,          0);
      chk("req_ready", bus.req_ready, 1);
    end
    chk("err_zero", err_zero, m_err);
  endtask

  task automatic step(input bit v, input logic [N-1:0] d, input bit r);
    bus.req_valid = v;
    bus.req_in    = d;
    bus.enc_ready = r;
    m_err = 1'b0;
    if (q.size() == 0) begin
      if (v) begin
        if (d == '0) m_err = 1'b1;
        else load(d);
      end
    end else if (r) begin
      m_ptr = (q[0] + 1) % N;
      void'(q.pop_front());
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

`ifdef COD_RR_EN
  int exp92[3]  = '{4, 7, 1};
  int exp09[2]  = '{3, 0};
`else
  int exp92[3]  = '{1, 4, 7};
  int exp09[2]  = '{0, 3};
`endif

  initial begin
    int first;
    bus.req_valid = 1'b0;
    bus.req_in    = '0;
    bus.enc_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // single bit
    step(1, 8'h04, 0);
    chk("single_idx", bus.enc_out, 2);
    chk("single_last", bus.enc_last, 1);
    step(0, '0, 1);
    chk("single_rdy", bus.req_ready, 1);

    // multi-bit drain with sustained ready
    step(1, 8'h92, 1);
    for (int i = 0; i < 3; i++) begin
      chk("drain_idx", bus.enc_out, exp92[i]);
      chk("drain_last", bus.enc_last, (i == 2) ? 1 : 0);
      step(0, '0, 1);
    end

    // back-pressure: output held for 5 cycles
    step(1, 8'h92, 0);
    first = q[0];
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h55, 0);
      chk("bp_hold", bus.enc_out, first);
      chk("bp_last", bus.enc_last, 0);
    end
    repeat (3) step(0, '0, 1);

    // zero vector
    step(1, 8'h00, 0);
    chk("zero_pulse", err_zero, 1);
    step(0, '0, 0);
    chk("zero_clear", err_zero, 0);

    // reset in the middle of a drain
    step(1, 8'hFF, 1);
    step(0, '0, 1);
    step(0, '0, 1);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_ptr = 0;
    m_err = 1'b0;
    chk("rst_mid_valid", bus.enc_valid, 0);
    chk("rst_mid_busy", busy, 0);
    #2;
    rst_n = 1'b1;
    step(1, 8'h01, 1);
    chk("post_rst_idx", bus.enc_out, 0);
    step(0, '0, 1);

    // priority order across vectors
    step(1, 8'h04, 1);
    chk("prio_a", bus.enc_out, 2);
    step(0, '0, 1);
    step(1, 8'h09, 1);
    chk("prio_b0", bus.enc_out, exp09[0]);
    step(0, '0, 1);
    chk("prio_b1", bus.enc_out, exp09[1]);
    step(0, '0, 1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      bit          v;
      bit          r;
      logic [N-1:0] d;
      v = ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      r = ($urandom_range(0, 9) < 7);
      step(v, d, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
